// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between I-cache and D-cache.
// Alternates grants on ties; one RELEASE cycle follows every completed transfer.
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        RELEASE
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_req, d_req;
    logic              grant_i, grant_d;
    logic              busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // On a tie the requester not served last wins.
    always_comb begin
        i_req   = icache_read;
        d_req   = dcache_read | dcache_write;
        grant_d = d_req & (~i_req | ~last_d_q);
        grant_i = i_req & ~grant_d;
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = D_BUSY;
                    addr_d  = dcache_address;
                    wdata_d = dcache_wdata;
                    wr_d    = dcache_write;
                end else if (grant_i) begin
                    state_d = I_BUSY;
                    addr_d  = icache_address;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                end
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    state_d  = RELEASE;
                    last_d_d = 1'b0;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    state_d  = RELEASE;
                    last_d_d = 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == I_BUSY) | (state_q == D_BUSY);
        pmem_read    = busy & ~wr_q;
        pmem_write   = busy & wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
        icache_resp  = (state_q == I_BUSY) & pmem_resp;
        dcache_resp  = (state_q == D_BUSY) & pmem_resp;
        icache_rdata = icache_resp ? pmem_rdata : '0;
        dcache_rdata = dcache_resp ? pmem_rdata : '0;
    end

endmodule
